// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the mem_responder memory-side responder.
package mem_responder_types;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2,
        TURN = 2'd3
    } resp_state_t;

    localparam int MAX_LATENCY = 15;
    localparam int CNT_W       = 4;

endpackage

// File: rtl/mem_responder_word_array.sv
// Word storage for mem_responder: one synchronous byte-lane write port and a
// combinational read port. Contents are deliberately not reset.
module mem_word_array #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [3:0]            be_i,
    input  logic [DEPTH_LOG2-1:0] waddr_i,
    input  logic [31:0]           wdata_i,
    input  logic [DEPTH_LOG2-1:0] raddr_i,
    output logic [31:0]           rdata_o
);

    logic [31:0] mem_q [0:(1<<DEPTH_LOG2)-1];

    // Byte-lane masked write; a zero mask leaves the word untouched.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int i = 0; i < 4; i++) begin
                if (be_i[i]) begin
                    mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: one outstanding word access at a time with a fixed
// latency, a backdoor preload port and a sticky protocol-error flag.
module mem_responder
    import mem_responder_types::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [3:0]            mem_byte_enable,
    input  logic [31:0]           mem_address,
    input  logic [31:0]           mem_wdata,
    output logic [31:0]           mem_rdata,
    output logic                  mem_resp,
    input  logic                  init_we,
    input  logic [DEPTH_LOG2-1:0] init_addr,
    input  logic [31:0]           init_data,
    output logic                  proto_err
);

    localparam logic [CNT_W-1:0] LAT_C = CNT_W'(LATENCY);

    resp_state_t           state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic                  is_wr_q, is_wr_d;
    logic [3:0]            be_q, be_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  resp_q, resp_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic                  req_s;
    logic [DEPTH_LOG2-1:0] req_idx_s;
    logic                  arr_we_s;
    logic [3:0]            arr_be_s;
    logic [DEPTH_LOG2-1:0] arr_waddr_s;
    logic [31:0]           arr_wdata_s;
    logic [DEPTH_LOG2-1:0] rd_idx_s;
    logic [31:0]           arr_rdata_s;
    logic                  unused_addr_s;

    assign req_s         = mem_read | mem_write;
    assign req_idx_s     = mem_address[DEPTH_LOG2+1:2];
    assign unused_addr_s = ^{mem_address[31:DEPTH_LOG2+2], mem_address[1:0]};

    mem_word_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clk     (clk),
        .we_i    (arr_we_s),
        .be_i    (arr_be_s),
        .waddr_i (arr_waddr_s),
        .wdata_i (arr_wdata_s),
        .raddr_i (rd_idx_s),
        .rdata_o (arr_rdata_s)
    );

    // Next-state, response data, error and array-port steering.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        is_wr_d     = is_wr_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        resp_d      = 1'b0;
        rdata_d     = rdata_q;
        err_d       = err_q;
        arr_we_s    = 1'b0;
        arr_be_s    = be_q;
        arr_waddr_s = idx_q;
        arr_wdata_s = wdata_q;
        rd_idx_s    = idx_q;

        case (state_q)
            IDLE: begin
                // Zero latency reads the incoming index before it is latched.
                rd_idx_s = req_idx_s;
                if (req_s) begin
                    idx_d   = req_idx_s;
                    is_wr_d = mem_write & ~mem_read;
                    be_d    = mem_byte_enable;
                    wdata_d = mem_wdata;
                    cnt_d   = LAT_C;
                    if (mem_read && mem_write) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
                    if (LATENCY == 0) begin
                        state_d = RESP;
                        resp_d  = 1'b1;
                        if (mem_write && !mem_read) begin
                            rdata_d = rdata_q;
                        end else begin
                            rdata_d = arr_rdata_s;
                        end
                    end else begin
                        state_d = WAIT;
                    end
                end else if (init_we) begin
                    arr_we_s    = 1'b1;
                    arr_be_s    = 4'hF;
                    arr_waddr_s = init_addr;
                    arr_wdata_s = init_data;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (!req_s) begin
                    err_d   = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = IDLE;
                end else if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = RESP;
                    resp_d  = 1'b1;
                    if (is_wr_q) begin
                        rdata_d = rdata_q;
                    end else begin
                        rdata_d = arr_rdata_s;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                arr_we_s = is_wr_q;
                state_d  = TURN;
            end
            TURN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (init_we && !((state_q == IDLE) && !req_s)) begin
            err_d = 1'b1;
        end else begin
            err_d = err_d;
        end
    end

    // State and output registers; array contents survive reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= {DEPTH_LOG2{1'b0}};
            is_wr_q <= 1'b0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
            resp_q  <= 1'b0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            is_wr_q <= is_wr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            resp_q  <= resp_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign mem_resp  = resp_q;
    assign mem_rdata = rdata_q;
    assign proto_err = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a LATENCY=2 instance (a_*) and a LATENCY=0
// instance (b_*) share stimulus; each test watches the instance it targets.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write;
    logic [3:0]  be;
    logic [31:0] addr, wdata;
    logic        init_we;
    logic [9:0]  init_addr;
    logic [31:0] init_data;
    logic [31:0] a_rdata, b_rdata;
    logic        a_resp, b_resp, a_err, b_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_responder #(.DEPTH_LOG2(10), .LATENCY(2)) dut_a (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .mem_byte_enable(be), .mem_address(addr), .mem_wdata(wdata),
        .mem_rdata(a_rdata), .mem_resp(a_resp), .init_we(init_we),
        .init_addr(init_addr), .init_data(init_data), .proto_err(a_err)
    );

    mem_responder #(.DEPTH_LOG2(10), .LATENCY(0)) dut_b (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .mem_byte_enable(be), .mem_address(addr), .mem_wdata(wdata),
        .mem_rdata(b_rdata), .mem_resp(b_resp), .init_we(init_we),
        .init_addr(init_addr), .init_data(init_data), .proto_err(b_err)
    );

    task automatic preload(input logic [9:0] ia, input logic [31:0] d);
        init_we   = 1'b1;
        init_addr = ia;
        init_data = d;
        @(negedge clk);
        init_we   = 1'b0;
        @(negedge clk);
    endtask

    // Issue one request and hold it until the selected instance responds.
    // lat counts negedges from drive to response; -1 means no response.
    task automatic access(input bit use_b, input logic rd, input logic wr,
                          input logic [31:0] ad, input logic [31:0] wd,
                          input logic [3:0] m, output logic [31:0] rdat,
                          output int lat);
        mem_read  = rd;
        mem_write = wr;
        addr      = ad;
        wdata     = wd;
        be        = m;
        lat       = -1;
        rdat      = 32'hDEAD_BEEF;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if ((use_b ? b_resp : a_resp) === 1'b1) begin
                lat  = k;
                rdat = use_b ? b_rdata : a_rdata;
                break;
            end
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        checks++;
        if (a_resp !== 1'b0) begin errors++; $display("FAIL reset_resp: got %b want 0", a_resp); end
        checks++;
        if (a_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h want 0", a_rdata); end
        checks++;
        if (a_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", a_err); end
    endtask

    task automatic test_read_latency();
        preload(10'd4, 32'h600D_F00D);
        preload(10'd5, 32'h1122_3344);
        mem_read = 1'b1;
        addr     = 32'h0000_0010;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checks++;
            if (a_resp !== (k == 3)) begin
                errors++;
                $display("FAIL read_lat cycle %0d: mem_resp=%b want %b", k, a_resp, (k == 3));
            end
            if (k == 3) begin
                checks++;
                if (a_rdata !== 32'h600D_F00D) begin
                    errors++;
                    $display("FAIL read_data: got %h want 600df00d", a_rdata);
                end
            end
        end
        mem_read = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_write();
        logic [31:0] r;
        int          lat;
        access(1'b0, 1'b0, 1'b1, 32'h14, 32'hAABB_CCDD, 4'b0101, r, lat);
        checks++;
        if (lat != 3) begin errors++; $display("FAIL write_lat: got %0d want 3", lat); end
        access(1'b0, 1'b1, 1'b0, 32'h14, 32'h0, 4'h0, r, lat);
        checks++;
        if (r !== 32'h11BB_33DD) begin errors++; $display("FAIL write_merge: got %h want 11bb33dd", r); end
        access(1'b0, 1'b0, 1'b1, 32'h14, 32'hFFFF_FFFF, 4'b0000, r, lat);
        checks++;
        if (lat != 3) begin errors++; $display("FAIL mask0_resp: lat %0d want 3", lat); end
        access(1'b0, 1'b1, 1'b0, 32'h14, 32'h0, 4'h0, r, lat);
        checks++;
        if (r !== 32'h11BB_33DD) begin errors++; $display("FAIL mask0_keep: got %h want 11bb33dd", r); end
    endtask

    task automatic test_alias();
        logic [31:0] r;
        int          lat;
        access(1'b0, 1'b1, 1'b0, 32'h0000_1010, 32'h0, 4'h0, r, lat);
        checks++;
        if (r !== 32'h600D_F00D || lat != 3) begin
            errors++;
            $display("FAIL alias: got %h lat %0d want 600df00d lat 3", r, lat);
        end
        checks++;
        if (a_err !== 1'b0) begin errors++; $display("FAIL err_clean: got %b want 0", a_err); end
    endtask

    task automatic test_both();
        logic [31:0] r;
        int          lat;
        access(1'b0, 1'b1, 1'b1, 32'h14, 32'h0, 4'hF, r, lat);
        checks++;
        if (r !== 32'h11BB_33DD || lat != 3) begin
            errors++;
            $display("FAIL both_read: got %h lat %0d want 11bb33dd lat 3", r, lat);
        end
        checks++;
        if (a_err !== 1'b1) begin errors++; $display("FAIL both_err: got %b want 1", a_err); end
        access(1'b0, 1'b1, 1'b0, 32'h14, 32'h0, 4'h0, r, lat);
        checks++;
        if (r !== 32'h11BB_33DD) begin errors++; $display("FAIL both_nowrite: got %h want 11bb33dd", r); end
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] r;
        int          lat;
        bit          seen;
        mem_read = 1'b1;
        addr     = 32'h10;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (a_resp !== 1'b0 || a_err !== 1'b0 || a_rdata !== 32'd0) begin
            errors++;
            $display("FAIL async_reset: resp=%b err=%b rdata=%h want 0 0 0", a_resp, a_err, a_rdata);
        end
        mem_read = 1'b0;
        @(negedge clk);
        rst  = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (a_resp === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL reset_abandon: mem_resp=1 want 0"); end
        access(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, r, lat);
        checks++;
        if (r !== 32'h600D_F00D || lat != 3) begin
            errors++;
            $display("FAIL reset_persist: got %h lat %0d want 600df00d lat 3", r, lat);
        end
    endtask

    task automatic test_drop();
        logic [31:0] r;
        int          lat;
        bit          seen;
        mem_write = 1'b1;
        addr      = 32'h10;
        wdata     = 32'h0;
        be        = 4'hF;
        @(negedge clk);
        mem_write = 1'b0;
        seen      = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (a_resp === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL drop_noresp: mem_resp=1 want 0"); end
        checks++;
        if (a_err !== 1'b1) begin errors++; $display("FAIL drop_err: got %b want 1", a_err); end
        access(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, r, lat);
        checks++;
        if (r !== 32'h600D_F00D) begin errors++; $display("FAIL drop_nowrite: got %h want 600df00d", r); end
    endtask

    task automatic test_latency0();
        logic [31:0] r;
        int          lat;
        preload(10'd4, 32'h600D_F00D);
        access(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, r, lat);
        checks++;
        if (r !== 32'h600D_F00D || lat != 1) begin
            errors++;
            $display("FAIL lat0_read: got %h lat %0d want 600df00d lat 1", r, lat);
        end
    endtask

    task automatic test_back_to_back();
        mem_read = 1'b1;
        addr     = 32'h10;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            checks++;
            if (b_resp !== ((k % 3) == 1)) begin
                errors++;
                $display("FAIL b2b cycle %0d: mem_resp=%b want %b", k, b_resp, ((k % 3) == 1));
            end
            if ((k % 3) == 1) begin
                checks++;
                if (b_rdata !== 32'h600D_F00D) begin
                    errors++;
                    $display("FAIL b2b_data cycle %0d: got %h want 600df00d", k, b_rdata);
                end
            end
        end
        mem_read = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        rst       = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        be        = 4'h0;
        addr      = 32'h0;
        wdata     = 32'h0;
        init_we   = 1'b0;
        init_addr = 10'd0;
        init_data = 32'h0;
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b1;
        @(negedge clk);
        test_read_latency();
        test_write();
        test_alias();
        test_both();
        test_reset_mid_wait();
        test_drop();
        test_latency0();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the multicycle RV32I datapath/control memory interface: mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata, mem_rdata and mem_resp.
- Services one outstanding word access at a time from an internal word array, after a fixed, parameterised latency.
- Serves as the bench/FPGA memory behind the CPU core.
- Also provides a backdoor preload port and a sticky protocol-error flag.

Parameters:
- DEPTH_LOG2, default 10: log2 of word count; array is 2**DEPTH_LOG2 x 32 bits.
- LATENCY, default 2: wait cycles between request acceptance and mem_resp. Legal range 0..15.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: asynchronous, active-low reset.
- mem_read, input, 1: read request, held until mem_resp.
- mem_write, input, 1: write request, held until mem_resp.
- mem_byte_enable, input, 4: write lane mask; bit i selects byte i.
- mem_address, input, 32: byte address; bits [1:0] ignored.
- mem_wdata, input, 32: write data.
- mem_rdata, output, 32: read data, valid only in the mem_resp cycle.
- mem_resp, output, 1: one-cycle completion pulse.
- init_we, input, 1: backdoor word write.
- init_addr, input, DEPTH_LOG2: backdoor word index.
- init_data, input, 32: backdoor data.
- proto_err, output, 1: sticky protocol-error flag.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, mem_resp=0, mem_rdata=0, proto_err=0, latency counter=0. Array contents are not cleared.
- Word index = mem_address[DEPTH_LOG2+1:2]. Higher address bits are ignored, so addresses alias modulo the array size.
- States are IDLE, WAIT, RESP, TURN.
- IDLE, with mem_read or mem_write high at edge t:
  - Latch index, op, byte_enable and wdata.
  - Load counter with LATENCY.
  - Go to WAIT, or directly to RESP if LATENCY=0.
- WAIT:
  - Decrement the counter each cycle; go to RESP when it reaches 0 or is 0 on entry.
  - mem_resp is asserted on the cycle after edge t+LATENCY. For LATENCY=2, mem_resp is high in cycle t+3, i.e. 3 cycles after the request is first sampled.
- RESP, one cycle, mem_resp=1:
  - Read: mem_rdata = array[index].
  - Write: at the end of the cycle, each byte lane i with mask bit 1 is written from wdata lane i.
  - mask=0000 is a legal no-op write that still responds.
  - Always go to TURN.
- TURN: one cycle with mem_resp=0. Requests are ignored so that a request still held during the initiator's state change is not serviced twice. Then go to IDLE.
- mem_rdata holds its last value outside RESP. Consumers must sample it only while mem_resp=1.
- Simultaneous mem_read and mem_write sampled in IDLE: proto_err sets, and the access is treated as a read with a normal response.
- Request dropped (both low) during WAIT: proto_err sets, the access is abandoned, no write occurs, no mem_resp, return to IDLE.
- Latched fields are frozen at acceptance. Changes to address, wdata or mask during WAIT are ignored and do not flag an error.
- Backdoor port:
  - init_we is honoured only in IDLE with no request present.
  - It is ignored in all other cycles, and proto_err sets if it is asserted then.
  - Writes the full word and produces no mem_resp.
- proto_err clears only on reset.

Decomposition:
- Package mem_responder_types holds:
  - typedef enum resp_state_t {IDLE, WAIT, RESP, TURN};
  - constant MAX_LATENCY = 15;
  - latency counter width = 4.
- Sub-module mem_word_array holds the storage:
  - Synchronous byte-lane write port shared by the access path and the backdoor path, muxed by the FSM.
  - Combinational read of the latched index.
- The FSM, counter and error logic stay in mem_responder.

Test Plan:
- Preload array[4]=0x600D_F00D via init_we. Hold mem_read with address 0x0000_0010, LATENCY=2 → mem_resp high exactly 3 cycles after the request is sampled, mem_rdata=0x600DF00D; mem_resp low in the following cycle even though mem_read is still high.
- Write address 0x14, wdata 0xAABBCCDD, mask 0101 over prior content 0x11223344 → read back 0x11BB33DD; mask 0000 → content unchanged, mem_resp still pulses.
- LATENCY=0: a read of address 0x10 → mem_resp in the cycle after sampling; back-to-back requests are serviced at 3-cycle spacing (accept, RESP, TURN).
- Assert mem_read and mem_write together → proto_err=1 and read data returned. Separately, drop mem_write mid-WAIT → no mem_resp, memory unchanged, proto_err=1.
- Assert rst low asynchronously mid-WAIT (between clock edges) → mem_resp=0 and state IDLE immediately; preloaded contents persist; proto_err=0.
- Address 0x0000_1010 with DEPTH_LOG2=10 → aliases to word 4 and returns 0x600DF00D.
